// File: rtl/param_sort_unit.sv
// Iterative odd-even transposition sorter: one compare/swap phase per clock,
// optional early exit after two quiet phases, registered result and median.
module param_sort_unit #(
   parameter int N          = 9,
   parameter int BIT_WIDTH  = 8,
   parameter int EARLY_EXIT = 0
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   start_i,
   input  logic                   desc_i,
   input  logic [N*BIT_WIDTH-1:0] in_data_i,
   output logic [N*BIT_WIDTH-1:0] out_data_o,
   output logic [BIT_WIDTH-1:0]   median_o,
   output logic                   busy_o,
   output logic                   valid_o
);
   localparam int PW  = $clog2(N + 1);
   localparam int MED = (N - 1) / 2;

   typedef enum logic {S_IDLE, S_SORT} state_t;
   state_t r_state, w_state_next;

   logic [BIT_WIDTH-1:0]   r_arr      [N];
   logic [BIT_WIDTH-1:0]   w_arr_next [N];
   logic [N*BIT_WIDTH-1:0] w_arr_packed;
   logic [N-2:0]           w_swap;
   logic                   r_desc;
   logic [PW-1:0]          r_phase;
   logic [1:0]             r_quiet;
   logic [1:0]             w_quiet_next;
   logic                   w_any_swap;
   logic                   w_last_phase;
   logic                   w_load;
   logic                   w_done;

   genvar gi;

   // Pair (gi, gi+1) is active when its left index has the phase's parity.
   generate
      for (gi = 0; gi < N - 1; gi++) begin : g_pair
         localparam logic LP_ODD = ((gi % 2) == 1);
         assign w_swap[gi] = (r_phase[0] == LP_ODD) &&
                             (r_desc ? (r_arr[gi] < r_arr[gi+1])
                                     : (r_arr[gi] > r_arr[gi+1]));
      end

      for (gi = 0; gi < N; gi++) begin : g_elem
         if (gi == 0) begin : g_first
            assign w_arr_next[gi] = w_swap[gi] ? r_arr[gi+1] : r_arr[gi];
         end else if (gi == N - 1) begin : g_last
            assign w_arr_next[gi] = w_swap[gi-1] ? r_arr[gi-1] : r_arr[gi];
         end else begin : g_mid
            assign w_arr_next[gi] = w_swap[gi]   ? r_arr[gi+1] :
                                    w_swap[gi-1] ? r_arr[gi-1] : r_arr[gi];
         end
         assign w_arr_packed[gi*BIT_WIDTH +: BIT_WIDTH] = w_arr_next[gi];
      end
   endgenerate

   always_comb begin
      w_state_next = r_state;
      w_load       = 1'b0;
      w_done       = 1'b0;
      w_any_swap   = |w_swap;
      w_last_phase = (r_phase == PW'(N - 1));
      w_quiet_next = w_any_swap ? 2'd0 : r_quiet + 2'd1;
      case (r_state)
         S_IDLE: begin
            if (start_i) begin
               w_load       = 1'b1;
               w_state_next = S_SORT;
            end
         end
         S_SORT: begin
            if (w_last_phase || ((EARLY_EXIT != 0) && (w_quiet_next == 2'd2))) begin
               w_done       = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state <= S_IDLE;
         for (int k = 0; k < N; k++) r_arr[k] <= '0;
         r_desc     <= 1'b0;
         r_phase    <= '0;
         r_quiet    <= '0;
         out_data_o <= '0;
         median_o   <= '0;
         valid_o    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         valid_o <= w_done;
         if (w_load) begin
            for (int k = 0; k < N; k++) r_arr[k] <= in_data_i[k*BIT_WIDTH +: BIT_WIDTH];
            r_desc  <= desc_i;
            r_phase <= '0;
            r_quiet <= '0;
         end else if (r_state == S_SORT) begin
            for (int k = 0; k < N; k++) r_arr[k] <= w_arr_next[k];
            r_phase <= r_phase + PW'(1);
            r_quiet <= w_quiet_next;
         end
         // The terminating phase result goes straight to the outputs.
         if (w_done) begin
            out_data_o <= w_arr_packed;
            median_o   <= w_arr_next[MED];
         end
      end
   end

   assign busy_o = (r_state == S_SORT);

endmodule

// File: tb/tb_param_sort_unit.sv
// Bench for param_sort_unit: three instances (N=9 plain, N=9 early exit, N=25x12b)
// checked every cycle against a queue/array-level reference sorter.
module tb_param_sort_unit;
   typedef int arr_t [32];

   logic         clk;
   logic         rst;
   logic         st_ab, desc_ab;
   logic [71:0]  din_ab;
   logic [71:0]  out_a, out_b;
   logic [7:0]   med_a, med_b;
   logic         busy_a, busy_b, val_a, val_b;
   logic         st_c, desc_c;
   logic [299:0] din_c;
   logic [299:0] out_c;
   logic [11:0]  med_c;
   logic         busy_c, val_c;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit chk_en = 1'b0;

   param_sort_unit #(.N(9), .BIT_WIDTH(8), .EARLY_EXIT(0)) u_a (
      .CLK(clk), .RST(rst), .start_i(st_ab), .desc_i(desc_ab), .in_data_i(din_ab),
      .out_data_o(out_a), .median_o(med_a), .busy_o(busy_a), .valid_o(val_a));
   param_sort_unit #(.N(9), .BIT_WIDTH(8), .EARLY_EXIT(1)) u_b (
      .CLK(clk), .RST(rst), .start_i(st_ab), .desc_i(desc_ab), .in_data_i(din_ab),
      .out_data_o(out_b), .median_o(med_b), .busy_o(busy_b), .valid_o(val_b));
   param_sort_unit #(.N(25), .BIT_WIDTH(12), .EARLY_EXIT(0)) u_c (
      .CLK(clk), .RST(rst), .start_i(st_c), .desc_i(desc_c), .in_data_i(din_c),
      .out_data_o(out_c), .median_o(med_c), .busy_o(busy_c), .valid_o(val_c));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   function automatic arr_t unpack(logic [383:0] v, int n, int bw);
      arr_t r;
      for (int i = 0; i < 32; i++) r[i] = 0;
      for (int i = 0; i < n; i++)
         for (int b = 0; b < bw; b++) r[i][b] = v[i*bw + b];
      return r;
   endfunction

   function automatic logic [383:0] pack(arr_t a, int n, int bw);
      logic [383:0] v;
      v = '0;
      for (int i = 0; i < n; i++)
         for (int b = 0; b < bw; b++) v[i*bw + b] = a[i][b];
      return v;
   endfunction

   function automatic arr_t ref_sort(arr_t a, int n, bit desc);
      int key, j;
      for (int i = 1; i < n; i++) begin
         key = a[i];
         j = i - 1;
         while (j >= 0 && (desc ? (a[j] < key) : (a[j] > key))) begin
            a[j+1] = a[j];
            j--;
         end
         a[j+1] = key;
      end
      return a;
   endfunction

   // Number of phase edges until termination, from the odd-even phase rules.
   function automatic int ref_latency(arr_t a, int n, bit desc, bit ee);
      int quiet, swaps, t;
      quiet = 0;
      for (int p = 0; p < n; p++) begin
         swaps = 0;
         for (int i = p % 2; i + 1 < n; i += 2) begin
            if (desc ? (a[i] < a[i+1]) : (a[i] > a[i+1])) begin
               t = a[i]; a[i] = a[i+1]; a[i+1] = t;
               swaps++;
            end
         end
         quiet = (swaps == 0) ? quiet + 1 : 0;
         if (ee && quiet == 2) return p + 1;
      end
      return n;
   endfunction

   arr_t in_ab, in_c;
   arr_t cap_sort [3];
   int   cap_lat  [3];
   bit   m_busy   [3];
   bit   m_valid  [3];
   int   m_rem    [3];
   arr_t m_exp    [3];
   arr_t m_out    [3];

   always_comb begin
      in_ab = unpack({312'd0, din_ab}, 9, 8);
      in_c  = unpack({84'd0, din_c}, 25, 12);
      cap_sort[0] = ref_sort(in_ab, 9, desc_ab);
      cap_sort[1] = cap_sort[0];
      cap_sort[2] = ref_sort(in_c, 25, desc_c);
      cap_lat[0]  = ref_latency(in_ab, 9, desc_ab, 1'b0);
      cap_lat[1]  = ref_latency(in_ab, 9, desc_ab, 1'b1);
      cap_lat[2]  = ref_latency(in_c, 25, desc_c, 1'b0);
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 3; k++) begin
            m_busy[k]  <= 1'b0;
            m_valid[k] <= 1'b0;
            m_rem[k]   <= 0;
            for (int i = 0; i < 32; i++) m_out[k][i] <= 0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            m_valid[k] <= 1'b0;
            if (m_busy[k]) begin
               if (m_rem[k] == 1) begin
                  m_busy[k]  <= 1'b0;
                  m_valid[k] <= 1'b1;
                  for (int i = 0; i < 32; i++) m_out[k][i] <= m_exp[k][i];
               end else begin
                  m_rem[k] <= m_rem[k] - 1;
               end
            end else if ((k < 2) ? st_ab : st_c) begin
               m_busy[k] <= 1'b1;
               m_rem[k]  <= cap_lat[k];
               for (int i = 0; i < 32; i++) m_exp[k][i] <= cap_sort[k][i];
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [383:0] act, input logic [383:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every instance against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy_a",  384'(busy_a), 384'(m_busy[0]));
         chk("valid_a", 384'(val_a),  384'(m_valid[0]));
         chk("out_a",   384'(out_a),  pack(m_out[0], 9, 8));
         chk("med_a",   384'(med_a),  384'(m_out[0][4]));
         chk("busy_b",  384'(busy_b), 384'(m_busy[1]));
         chk("valid_b", 384'(val_b),  384'(m_valid[1]));
         chk("out_b",   384'(out_b),  pack(m_out[1], 9, 8));
         chk("med_b",   384'(med_b),  384'(m_out[1][4]));
         chk("busy_c",  384'(busy_c), 384'(m_busy[2]));
         chk("valid_c", 384'(val_c),  384'(m_valid[2]));
         chk("out_c",   384'(out_c),  pack(m_out[2], 25, 12));
         chk("med_c",   384'(med_c),  384'(m_out[2][12]));
      end
   end

   // ---------------- stimulus ----------------
   localparam logic [71:0] D_S1     = 72'h050208060401070309; // 9 3 7 1 4 6 8 2 5
   localparam logic [71:0] D_ASC    = 72'h090807060504030201; // 1..9
   localparam logic [71:0] D_DESC   = 72'h010203040506070809; // 9..1
   localparam logic [71:0] D_DUP    = 72'h018080000707FF00FF; // 255 0 255 7 7 0 128 128 1
   localparam logic [71:0] D_DUP_S  = 72'hFFFF80800707010000; // 0 0 1 7 7 128 128 255 255

   task automatic run_ab(input logic [71:0] d, input logic ds, output int la, output int lb);
      int cap;
      la = -1;
      lb = -1;
      @(negedge clk);
      din_ab = d; desc_ab = ds; st_ab = 1'b1;
      @(posedge clk);
      #1 cap = cyc;
      @(negedge clk);
      st_ab = 1'b0;
      for (int i = 0; i < 60 && (la < 0 || lb < 0); i++) begin
         if (val_a && la < 0) la = cyc - cap;
         if (val_b && lb < 0) lb = cyc - cap;
         if (la < 0 || lb < 0) @(negedge clk);
      end
   endtask

   task automatic wait_val_a();
      for (int i = 0; i < 60 && !val_a; i++) @(negedge clk);
      chk("wait_val_a", 384'(val_a), 384'(1));
   endtask

   int la, lb, lc, nv, cap, idx, t;
   arr_t perm;
   logic [383:0] tmp;

   initial begin
      rst = 1'b1; st_ab = 1'b0; desc_ab = 1'b0; din_ab = '0;
      st_c = 1'b0; desc_c = 1'b0; din_c = '0;
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      chk_en = 1'b1;
      chk("rst_out_a", 384'(out_a), 384'(0));
      chk("rst_busy_a", 384'(busy_a), 384'(0));

      run_ab(D_S1, 1'b0, la, lb);
      chk("s1_lat_a", 384'(la), 384'(9));
      chk("s1_out_a", 384'(out_a), 384'(D_ASC));
      chk("s1_med_a", 384'(med_a), 384'(5));
      chk("s1_lat_b_le9", 384'(lb > 0 && lb <= 9), 384'(1));

      run_ab(D_S1, 1'b1, la, lb);
      chk("desc_lat_a", 384'(la), 384'(9));
      chk("desc_out_a", 384'(out_a), 384'(D_DESC));
      chk("desc_med_a", 384'(med_a), 384'(5));

      run_ab(D_ASC, 1'b0, la, lb);
      chk("sorted_lat_b", 384'(lb), 384'(2));
      chk("sorted_out_b", 384'(out_b), 384'(D_ASC));
      chk("model_lat_sorted", 384'(ref_latency(unpack({312'd0, D_ASC}, 9, 8), 9, 1'b0, 1'b1)), 384'(2));

      run_ab(D_DUP, 1'b0, la, lb);
      chk("dup_out_a", 384'(out_a), 384'(D_DUP_S));
      chk("dup_med_a", 384'(med_a), 384'(7));

      // start held high across the sort, data changed mid-sort
      @(negedge clk);
      din_ab = D_S1; desc_ab = 1'b0; st_ab = 1'b1;
      repeat (3) @(negedge clk);
      din_ab = D_DUP;
      wait_val_a();
      chk("hs_first_out_a", 384'(out_a), 384'(D_ASC));
      @(negedge clk);
      chk("hs_second_busy_a", 384'(busy_a), 384'(1));
      st_ab = 1'b0;
      wait_val_a();
      chk("hs_second_out_a", 384'(out_a), 384'(D_DUP_S));
      repeat (12) @(negedge clk);

      // reset during phase 4
      @(negedge clk);
      din_ab = D_DESC; st_ab = 1'b1;
      @(negedge clk);
      st_ab = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      nv = 0;
      repeat (15) begin
         @(negedge clk);
         if (val_a) nv++;
      end
      chk("rst_mid_no_valid", 384'(nv), 384'(0));
      chk("rst_mid_out_a", 384'(out_a), 384'(0));
      chk("rst_mid_busy_a", 384'(busy_a), 384'(0));
      run_ab(D_S1, 1'b0, la, lb);
      chk("post_rst_out_a", 384'(out_a), 384'(D_ASC));
      chk("post_rst_lat_a", 384'(la), 384'(9));

      // N=25, 12-bit: random permutation of 0..24
      for (int i = 0; i < 32; i++) perm[i] = (i < 25) ? i : 0;
      for (int i = 24; i > 0; i--) begin
         idx = $urandom_range(i, 0);
         t = perm[i]; perm[i] = perm[idx]; perm[idx] = t;
      end
      tmp = pack(perm, 25, 12);
      @(negedge clk);
      din_c = tmp[299:0]; desc_c = 1'b0; st_c = 1'b1;
      @(posedge clk);
      #1 cap = cyc;
      @(negedge clk);
      st_c = 1'b0;
      lc = -1;
      for (int i = 0; i < 80 && lc < 0; i++) begin
         if (val_c) lc = cyc - cap;
         else @(negedge clk);
      end
      chk("c_lat", 384'(lc), 384'(25));
      chk("c_med", 384'(med_c), 384'(12));
      for (int i = 0; i < 32; i++) perm[i] = (i < 25) ? i : 0;
      chk("c_out", 384'(out_c), pack(perm, 25, 12));

      // randomized traffic on all instances
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         st_ab   = ($urandom_range(3, 0) == 0);
         desc_ab = $urandom_range(1, 0);
         case ($urandom_range(2, 0))
            0: for (int i = 0; i < 9; i++) din_ab[i*8 +: 8] = 8'($urandom_range(255, 0));
            1: for (int i = 0; i < 9; i++) din_ab[i*8 +: 8] = 8'($urandom_range(3, 0));
            default: for (int i = 0; i < 9; i++) din_ab[i*8 +: 8] = 8'(i * 20 + $urandom_range(25, 0));
         endcase
         st_c   = ($urandom_range(3, 0) == 0);
         desc_c = $urandom_range(1, 0);
         for (int i = 0; i < 25; i++) din_c[i*12 +: 12] = 12'($urandom_range(4095, 0));
      end
      @(negedge clk);
      st_ab = 1'b0;
      st_c  = 1'b0;
      repeat (40) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
